mem_stream: RTL
===============

# mem_stream

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It registers the execute stage's results, receives load data from the synchronous data SRAM, and aligns and sign/zero-extends it for byte, halfword and word loads. It holds that load data stable while write-back stalls, and produces the write-back payload plus a forwarding view for the decode stage.

## Interface
Parameters: none.

Clock and reset:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.

From the execute stage:
- `EXE_to_MEM_valid` in 1: execute stage offers an instruction.
- `MEM_pc_in` in 32: instruction PC.
- `MEM_alu_res_in` in 32: ALU result. For loads this is the byte address.
- `MEM_res_from_mem_in` in 1: the result comes from memory (load).
- `MEM_mem_op_in` in 3: load type (package constants).
- `MEM_rf_we_in` in 1: register write enable.
- `MEM_rf_waddr_in` in 5: destination register.
- `data_sram_rdata` in 32: SRAM read data. It is valid only in the first cycle after the request.

From the write-back stage:
- `WB_allowin` in 1: write-back can accept.

Outputs to write-back and decode:
- `MEM_pc_out` out 32: registered PC.
- `MEM_rf_we_out` out 1: `rf_we` AND `MEM_valid`.
- `MEM_rf_waddr_out` out 5: registered destination register.
- `MEM_rf_wdata_out` out 32: aligned load data, or the ALU result.
- `MEM_fwd_valid_out` out 1: `MEM_valid` AND `rf_we` AND (`waddr` != 0). Decode may bypass `MEM_rf_wdata_out`.

Pipeline control:
- `MEM_to_WB_valid` out 1: `MEM_valid` AND `MEM_ready_go`.
- `MEM_allowin` out 1: (NOT `MEM_valid`) OR (`MEM_ready_go` AND `WB_allowin`).

## Operation
- `MEM_ready_go` is constant 1. The stage never stalls by itself.
- Accept: when `EXE_to_MEM_valid` AND `MEM_allowin`, latch all `*_in` payload fields.
- `MEM_valid` update: when `MEM_allowin`, load it with `EXE_to_MEM_valid`; otherwise hold.
- State `first` (1 bit):
  - Set on accept.
  - Cleared the cycle after accept, or when the instruction leaves.
  - While `first`=1, `data_sram_rdata` belongs to the current instruction.
- Read-data buffer `rbuf` (32 bits) with flag `rbuf_vld`:
  - Capture: in a cycle with `MEM_valid`, `first`=1, `res_from_mem`=1 and `WB_allowin`=0, load `rbuf` from `data_sram_rdata` and set `rbuf_vld`.
  - Clear `rbuf_vld` on accept of a new instruction, or when the instruction leaves (`MEM_to_WB_valid` AND `WB_allowin`).
  - Raw word selection: `rbuf_vld` ? `rbuf` : `data_sram_rdata`.
- Load alignment, with `a` = `alu_res[1:0]`:
  - `LD_W`: the raw word.
  - `LD_B` / `LD_BU`: byte `a` (bits 8a+7:8a), sign- or zero-extended to 32.
  - `LD_H` / `LD_HU`: halfword `a[1]`, sign- or zero-extended. `a[0]` is ignored; no misalignment detection.
  - Undefined encodings (101, 110, 111) behave as `LD_W`.
- `MEM_rf_wdata_out` = `res_from_mem` ? aligned data : `alu_res`.
- Stores require no MEM action; they pass through with `rf_we`=0.

## Timing
- Reset values: `MEM_valid`, `first`, `rbuf_vld` = 0; payload registers = 0; `rbuf` = 0.
  - Therefore `MEM_to_WB_valid`=0, `MEM_allowin`=1, `MEM_rf_we_out`=0, `MEM_fwd_valid_out`=0, `MEM_pc_out`=0, `MEM_rf_waddr_out`=0, `MEM_rf_wdata_out`=0.
- Latency: an instruction accepted at edge N presents `MEM_to_WB_valid` in cycle N+1. It leaves at the first edge where `WB_allowin`=1.
- Back-to-back: leave and accept at the same edge give full throughput. The new instruction sees `first`=1, and the old buffer is discarded.
- Stall: `MEM_rf_wdata_out` stays constant over any number of stall cycles, even though `data_sram_rdata` changes after the first cycle.
- Reset asserted mid-stall clears all state immediately, independent of the clock. No output glitch is required after the edge.
- Empty stage with `WB_allowin`=0: `MEM_allowin`=1, and an accept proceeds.

## Structure
- Shared package `mycpu_pkg`:
  - Load-op constants: `LD_W`=3'b000, `LD_B`=3'b001, `LD_H`=3'b010, `LD_BU`=3'b011, `LD_HU`=3'b100.
  - Width constants: 32-bit data, 5-bit register address.
- One sub-module, `load_align`, which is purely combinational:
  - Inputs: raw word, `addr[1:0]`, `mem_op`.
  - Output: 32-bit aligned result.
- Valid, handshake, `first` and buffer logic stay in `mem_stream`.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle, outside any clock edge. All outputs go to their reset values at once, and `MEM_allowin`=1.
- ALU pass-through: `alu_res`=0x1234_5678, `res_from_mem`=0, `rf_we`=1, `waddr`=5, `WB_allowin`=1.
  - Cycle N+1: `MEM_to_WB_valid`=1, `wdata`=0x1234_5678, `fwd_valid`=1.
  - Same case with `waddr`=0: `fwd_valid`=0.
- Byte/half extension, with `rdata`=0x80FF_7F01:
  - `LD_B` a=3: 0xFFFF_FF80.
  - `LD_BU` a=3: 0x0000_0080.
  - `LD_H` a=2: 0xFFFF_80FF.
  - `LD_HU` a=0: 0x0000_7F01.
  - `LD_W`: 0x80FF_7F01.
- Stall hold: `LD_W`, `rdata`=0xDEAD_BEEF in the first cycle, `WB_allowin`=0 for 3 cycles while `rdata` changes to 0x0.
  - `wdata` stays 0xDEAD_BEEF.
  - `MEM_allowin`=0 during the stall.
  - The instruction leaves when `WB_allowin`=1.
- Back-to-back loads: two `LD_W` accepted on consecutive edges with `rdata` 0xA and then 0xB. `wdata` reads 0xA, then 0xB, and no stale buffer is used.
- Bubble: `EXE_to_MEM_valid`=0 with an empty stage. `MEM_to_WB_valid`=0, and `rf_we_out`=0 regardless of the payload inputs.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared definitions for the CPU pipeline: data/register widths, load-op encodings, MEM payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mycpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // Load type encodings carried on mem_op. Encodings 101..111 are unused and behave as LD_W.
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // Instruction state held by the MEM stage between accept and leave.
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_res;
    logic              res_from_mem;
    logic [2:0]        mem_op;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
  } mem_payload_t;

endpackage

// File: rtl/mem_stream_if.sv
// EXE -> MEM -> WB bundle: execute payload and SRAM read data in; write-back payload, forwarding and handshake out.
// Latency: n/a (wires only).
// Backpressure: WB_allowin / MEM_allowin valid-allowin handshake.
//   master: upstream/environment side (drives the execute payload, SRAM data and WB_allowin).
//   slave:  the mem_stream stage.
interface mem_stream_if;
  import mycpu_pkg::*;

  logic              EXE_to_MEM_valid;
  logic [DATA_W-1:0] MEM_pc_in;
  logic [DATA_W-1:0] MEM_alu_res_in;
  logic              MEM_res_from_mem_in;
  logic [2:0]        MEM_mem_op_in;
  logic              MEM_rf_we_in;
  logic [REG_AW-1:0] MEM_rf_waddr_in;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              WB_allowin;

  logic [DATA_W-1:0] MEM_pc_out;
  logic              MEM_rf_we_out;
  logic [REG_AW-1:0] MEM_rf_waddr_out;
  logic [DATA_W-1:0] MEM_rf_wdata_out;
  logic              MEM_fwd_valid_out;
  logic              MEM_to_WB_valid;
  logic              MEM_allowin;

  modport slave (
    input  EXE_to_MEM_valid, MEM_pc_in, MEM_alu_res_in, MEM_res_from_mem_in,
           MEM_mem_op_in, MEM_rf_we_in, MEM_rf_waddr_in, data_sram_rdata, WB_allowin,
    output MEM_pc_out, MEM_rf_we_out, MEM_rf_waddr_out, MEM_rf_wdata_out,
           MEM_fwd_valid_out, MEM_to_WB_valid, MEM_allowin
  );

  modport master (
    output EXE_to_MEM_valid, MEM_pc_in, MEM_alu_res_in, MEM_res_from_mem_in,
           MEM_mem_op_in, MEM_rf_we_in, MEM_rf_waddr_in, data_sram_rdata, WB_allowin,
    input  MEM_pc_out, MEM_rf_we_out, MEM_rf_waddr_out, MEM_rf_wdata_out,
           MEM_fwd_valid_out, MEM_to_WB_valid, MEM_allowin
  );

endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
//   Ports: raw (32b load word), addr (byte offset [1:0]), mem_op (load type) -> result (32b aligned data).
module load_align
  import mycpu_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        addr,
  input  logic [2:0]        mem_op,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    // addr[0] is ignored for halfwords; misaligned halves are not trapped here.
    half_sel = addr[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    result = raw;
    case (mem_op)
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'h000000, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'h0000, half_sel};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_stream.sv
// MEM pipeline stage: registers EXE results, aligns SRAM load data, holds it across WB stalls.
// Latency: 1 cycle (accepted at edge N, offered to WB in cycle N+1).
// Backpressure: never stalls itself; MEM_allowin follows WB_allowin while occupied.
//   Ports: clk, reset (async, active-high), bus (mem_stream_if.slave: EXE payload, SRAM rdata, WB handshake, WB/forward outputs).
module mem_stream
  import mycpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mem_stream_if.slave  bus
);

  localparam logic MEM_READY_GO = 1'b1;

  logic              mem_valid;
  logic              first;
  logic              rbuf_vld;
  logic [DATA_W-1:0] rbuf;
  mem_payload_t      pl;

  logic              accept;
  logic              leave;
  logic [DATA_W-1:0] raw_word;
  logic [DATA_W-1:0] aligned;

  assign bus.MEM_allowin     = !mem_valid || (MEM_READY_GO && bus.WB_allowin);
  assign bus.MEM_to_WB_valid = mem_valid && MEM_READY_GO;
  assign accept              = bus.EXE_to_MEM_valid && bus.MEM_allowin;
  assign leave               = bus.MEM_to_WB_valid && bus.WB_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid <= 1'b0;
      first     <= 1'b0;
      rbuf_vld  <= 1'b0;
      rbuf      <= '0;
      pl        <= '0;
    end else begin
      if (bus.MEM_allowin) begin
        mem_valid <= bus.EXE_to_MEM_valid;
      end
      if (accept) begin
        pl.pc           <= bus.MEM_pc_in;
        pl.alu_res      <= bus.MEM_alu_res_in;
        pl.res_from_mem <= bus.MEM_res_from_mem_in;
        pl.mem_op       <= bus.MEM_mem_op_in;
        pl.rf_we        <= bus.MEM_rf_we_in;
        pl.rf_waddr     <= bus.MEM_rf_waddr_in;
      end
      // SRAM data belongs to us only in the cycle right after accept.
      first <= accept;
      // The SRAM only drives valid data for one cycle; if WB is stalling in
      // that cycle, park the word so the output stays put until WB takes it.
      // Capture and clear cannot coincide: capture needs WB_allowin=0 with
      // the stage full, which blocks both accept and leave.
      if (accept || leave) begin
        rbuf_vld <= 1'b0;
      end else if (mem_valid && first && pl.res_from_mem && !bus.WB_allowin) begin
        rbuf     <= bus.data_sram_rdata;
        rbuf_vld <= 1'b1;
      end
    end
  end

  assign raw_word = rbuf_vld ? rbuf : bus.data_sram_rdata;

  load_align u_load_align (
    .raw    (raw_word),
    .addr   (pl.alu_res[1:0]),
    .mem_op (pl.mem_op),
    .result (aligned)
  );

  assign bus.MEM_pc_out        = pl.pc;
  assign bus.MEM_rf_we_out     = pl.rf_we && mem_valid;
  assign bus.MEM_rf_waddr_out  = pl.rf_waddr;
  assign bus.MEM_rf_wdata_out  = pl.res_from_mem ? aligned : pl.alu_res;
  assign bus.MEM_fwd_valid_out = mem_valid && pl.rf_we && (pl.rf_waddr != '0);

endmodule
